capture_sequencer: RTL and testbench

//  Sequences acquisition into the 640-entry display frame buffer: arm, holdoff, trigger detect,

---
 rtl/osc_pkg.sv | 24 ++
 rtl/trig_detect.sv | 39 +++
 rtl/capture_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_capture_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_pkg.sv
// Shared acquisition-path definitions used by the capture sequencer,
// the frame buffer and the VGA reader.
package osc_pkg;

    localparam int FRAME_DEPTH = 640;
    localparam int DATA_W      = 12;

    typedef enum logic [2:0] {
        IDLE,
        HOLDOFF,
        WAIT_TRIG,
        CAPTURE,
        DONE
    } cap_state_t;

    // Code 3 is reserved; it behaves exactly like NORMAL.
    typedef enum logic [1:0] {
        MODE_AUTO   = 2'd0,
        MODE_NORMAL = 2'd1,
        MODE_SINGLE = 2'd2,
        MODE_RSVD   = 2'd3
    } trig_mode_t;

endpackage

// File: rtl/trig_detect.sv
// Level/slope trigger detector: remembers the last valid sample and flags a
// threshold crossing on the current valid sample.
module trig_detect #(
    parameter int DATA_W = osc_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] level,
    input  logic              slope,
    output logic              crossing
);

    logic [DATA_W-1:0] prev_sample;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_sample <= '0;
        end else if (sample_valid) begin
            prev_sample <= sample;
        end
    end

    // slope 0 = rising through level, 1 = falling through level.
    always_comb begin
        crossing = 1'b0;
        if (sample_valid) begin
            if (slope) begin
                crossing = (prev_sample > level) && (sample <= level);
            end else begin
                crossing = (prev_sample < level) && (sample >= level);
            end
        end
    end

endmodule

// File: rtl/capture_sequencer.sv
// Acquisition sequencer: arm, holdoff, trigger search, decimated capture into
// the frame buffer, then handoff to the reader until frame_ack.
module capture_sequencer #(
    parameter int FRAME_DEPTH  = osc_pkg::FRAME_DEPTH,
    parameter int DATA_W       = osc_pkg::DATA_W,
    parameter int AUTO_TIMEOUT = 200000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic [1:0]        trig_mode,
    input  logic [7:0]        decim,
    input  logic [15:0]       holdoff,
    input  logic              arm,
    input  logic              stop,
    input  logic              frame_ack,
    output logic              wr_en,
    output logic [9:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_ready,
    output logic              busy,
    output logic              auto_trig
);

    import osc_pkg::*;

    localparam int              TO_W      = (AUTO_TIMEOUT > 2) ? $clog2(AUTO_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(AUTO_TIMEOUT - 1);
    localparam logic [9:0]      LAST_ADDR = 10'(FRAME_DEPTH - 1);

    cap_state_t        state;
    cap_state_t        next_state;

    // Per-frame configuration, frozen on every entry to HOLDOFF.
    trig_mode_t        mode_lat;
    logic [7:0]        decim_lat;
    logic [15:0]       holdoff_lat;
    logic [DATA_W-1:0] level_lat;
    logic              slope_lat;

    logic [15:0]       hold_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [7:0]        dec_cnt;
    logic [9:0]        addr_cnt;

    logic              crossing;
    logic              latch_cfg;
    logic              trig_fire;
    logic              trig_auto;
    logic              do_write;

    trig_detect #(
        .DATA_W (DATA_W)
    ) u_trig_detect (
        .clock        (clock),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .level        (level_lat),
        .slope        (slope_lat),
        .crossing     (crossing)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        latch_cfg  = 1'b0;
        trig_fire  = 1'b0;
        trig_auto  = 1'b0;
        do_write   = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    next_state = HOLDOFF;
                    latch_cfg  = 1'b1;
                end
            end
            HOLDOFF: begin
                if (hold_cnt == holdoff_lat) begin
                    next_state = WAIT_TRIG;
                end
            end
            WAIT_TRIG: begin
                // A genuine crossing takes priority over the AUTO timeout.
                if (crossing) begin
                    trig_fire = 1'b1;
                end else if (sample_valid && mode_lat == MODE_AUTO && to_cnt == TO_LAST) begin
                    trig_fire = 1'b1;
                    trig_auto = 1'b1;
                end
                if (trig_fire) begin
                    do_write   = 1'b1;
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (sample_valid && dec_cnt == 8'd0) begin
                    do_write = 1'b1;
                    if (addr_cnt == LAST_ADDR) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                if (frame_ack) begin
                    if (mode_lat == MODE_SINGLE) begin
                        next_state = IDLE;
                    end else begin
                        next_state = HOLDOFF;
                        latch_cfg  = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        if (stop) begin
            next_state = IDLE;
            latch_cfg  = 1'b0;
            trig_fire  = 1'b0;
            trig_auto  = 1'b0;
            do_write   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_lat    <= MODE_AUTO;
            decim_lat   <= '0;
            holdoff_lat <= '0;
            level_lat   <= '0;
            slope_lat   <= 1'b0;
        end else if (latch_cfg) begin
            mode_lat    <= trig_mode_t'(trig_mode);
            decim_lat   <= decim;
            holdoff_lat <= holdoff;
            level_lat   <= trig_level;
            slope_lat   <= trig_slope;
        end
    end

    // Counters terminate on compare-equal, so none of them can wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
            to_cnt   <= '0;
            dec_cnt  <= '0;
            addr_cnt <= '0;
        end else begin
            if (latch_cfg || stop) begin
                hold_cnt <= '0;
            end else if (state == HOLDOFF && sample_valid && hold_cnt != holdoff_lat) begin
                hold_cnt <= hold_cnt + 16'd1;
            end

            if (latch_cfg || stop) begin
                to_cnt <= '0;
            end else if (state == WAIT_TRIG && sample_valid && to_cnt != TO_LAST) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (stop) begin
                dec_cnt <= '0;
            end else if (do_write) begin
                dec_cnt <= decim_lat;
            end else if (state == CAPTURE && sample_valid) begin
                dec_cnt <= dec_cnt - 8'd1;
            end

            if (latch_cfg || stop) begin
                addr_cnt <= '0;
            end else if (do_write) begin
                addr_cnt <= addr_cnt + 10'd1;
            end
        end
    end

    // Write port is registered: wr_en, wr_addr and wr_data change together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_ready <= 1'b0;
            auto_trig   <= 1'b0;
        end else begin
            wr_en <= do_write;
            if (do_write) begin
                wr_addr <= addr_cnt;
                wr_data <= sample;
            end
            frame_ready <= (next_state == DONE);
            if (trig_fire) begin
                auto_trig <= trig_auto;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer: directed frames push expected writes,
// a negedge monitor pops and compares every frame-buffer write.
module tb_capture_sequencer;

    localparam int DATA_W = 12;

    typedef struct packed {
        logic [9:0]        addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clock;
    logic              reset;
    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] trig_level;
    logic              trig_slope;
    logic [1:0]        trig_mode;
    logic [7:0]        decim;
    logic [15:0]       holdoff;
    logic              arm;
    logic              stop;
    logic              frame_ack;
    logic              wr_en;
    logic [9:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_ready;
    logic              busy;
    logic              auto_trig;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  wr_count = 0;
    int  snap;
    int  hold_seq[10] = '{1500, 900, 1500, 900, 1500, 900, 1500, 900, 1500, 1500};

    capture_sequencer #(
        .FRAME_DEPTH  (640),
        .DATA_W       (DATA_W),
        .AUTO_TIMEOUT (50)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .trig_level   (trig_level),
        .trig_slope   (trig_slope),
        .trig_mode    (trig_mode),
        .decim        (decim),
        .holdoff      (holdoff),
        .arm          (arm),
        .stop         (stop),
        .frame_ack    (frame_ack),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_ready  (frame_ready),
        .busy         (busy),
        .auto_trig    (auto_trig)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clock) begin : monitor
        wr_t e;
        if (reset && wr_en) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=%0d data=%0d expected no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    task automatic push(input int addr, input int data);
        wr_t e;
        e.addr = 10'(addr);
        e.data = DATA_W'(data % 4096);
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(input int v);
        sample_valid = 1'b1;
        sample       = DATA_W'(v % 4096);
        tick(1);
        sample_valid = 1'b0;
    endtask

    task automatic send_ramp(input int first, input int last);
        for (int i = first; i <= last; i++) send(i);
    endtask

    task automatic configure(input int mode, input int slope, input int level, input int dec, input int hold);
        trig_mode  = 2'(mode);
        trig_slope = 1'(slope);
        trig_level = DATA_W'(level);
        decim      = 8'(dec);
        holdoff    = 16'(hold);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic pulse_ack();
        frame_ack = 1'b1;
        tick(1);
        frame_ack = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset = 1'b0; sample_valid = 1'b0; sample = '0; arm = 1'b0; stop = 1'b0; frame_ack = 1'b0;
        configure(0, 0, 0, 0, 0);
        tick(2);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_frame_ready", 32'(frame_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_auto_trig", 32'(auto_trig), 0);
        reset = 1'b1;
        tick(1);

        // 1: NORMAL rising at 2048, no decimation
        configure(1, 0, 2048, 0, 0);
        for (int k = 0; k < 640; k++) push(k, 2048 + k);
        pulse_arm();
        check("t1_busy_armed", 32'(busy), 1);
        tick(2);
        send_ramp(0, 2687);
        tick(2);
        check("t1_frame_ready", 32'(frame_ready), 1);
        check("t1_auto_trig", 32'(auto_trig), 0);
        check("t1_pending", 32'(exp_q.size()), 0);
        check("t1_writes", 32'(wr_count), 640);

        // 2: decimation by 4, ramp wraps past 4095
        configure(1, 0, 2048, 3, 0);
        for (int k = 0; k < 640; k++) push(k, 2048 + 4 * k);
        pulse_ack();
        check("t2_ready_cleared", 32'(frame_ready), 0);
        check("t2_busy_rearmed", 32'(busy), 1);
        tick(2);
        send_ramp(0, 4604);
        tick(2);
        check("t2_frame_ready", 32'(frame_ready), 1);
        check("t2_last_addr", 32'(wr_addr), 639);
        check("t2_last_data", 32'(wr_data), 508);
        check("t2_pending", 32'(exp_q.size()), 0);
        check("t2_writes", 32'(wr_count), 1280);

        // 3: AUTO with constant sample, forced trigger on the 50th valid
        configure(0, 0, 2048, 0, 0);
        for (int k = 0; k < 640; k++) push(k, 100);
        pulse_ack();
        tick(2);
        repeat (49) send(100);
        check("t3_no_write_before_timeout", 32'(wr_en), 0);
        send(100);
        check("t3_forced_wr_en", 32'(wr_en), 1);
        check("t3_forced_addr", 32'(wr_addr), 0);
        check("t3_auto_trig", 32'(auto_trig), 1);
        repeat (639) send(100);
        tick(2);
        check("t3_frame_ready", 32'(frame_ready), 1);
        check("t3_pending", 32'(exp_q.size()), 0);

        // 4: SINGLE frame, then ack returns to IDLE and crossings are ignored
        configure(2, 0, 2048, 0, 0);
        for (int k = 0; k < 640; k++) push(k, 2048 + k);
        pulse_ack();
        tick(2);
        send_ramp(0, 2687);
        tick(2);
        check("t4_frame_ready", 32'(frame_ready), 1);
        check("t4_auto_trig", 32'(auto_trig), 0);
        pulse_ack();
        check("t4_ready_cleared", 32'(frame_ready), 0);
        check("t4_busy_idle", 32'(busy), 0);
        snap = wr_count;
        send_ramp(2040, 2060);
        tick(2);
        check("t4_no_writes_idle", 32'(wr_count), 32'(snap));
        check("t4_still_idle", 32'(busy), 0);

        // 5: holdoff 10, falling at 1000; crossings inside holdoff ignored
        configure(1, 1, 1000, 0, 10);
        push(0, 1000);
        for (int k = 1; k < 640; k++) push(k, k);
        pulse_arm();
        snap = wr_count;
        for (int i = 0; i < 10; i++) send(hold_seq[i]);
        tick(2);
        check("t5_no_write_in_holdoff", 32'(wr_count), 32'(snap));
        send(1200);
        check("t5_no_trig_above", 32'(wr_en), 0);
        send(1000);
        check("t5_trig_wr_en", 32'(wr_en), 1);
        for (int k = 1; k < 640; k++) send(k);
        tick(2);
        check("t5_frame_ready", 32'(frame_ready), 1);
        check("t5_pending", 32'(exp_q.size()), 0);

        // 6a: stop at wr_addr 300
        configure(1, 0, 2048, 0, 0);
        for (int k = 0; k <= 300; k++) push(k, 2048 + k);
        pulse_ack();
        tick(2);
        send_ramp(0, 2348);
        check("t6_at_addr300", 32'(wr_addr), 300);
        stop = 1'b1; sample_valid = 1'b1; sample = DATA_W'(2349);
        tick(1);
        stop = 1'b0; sample_valid = 1'b0;
        check("t6_stop_wr_en", 32'(wr_en), 0);
        check("t6_stop_busy", 32'(busy), 0);
        check("t6_stop_ready", 32'(frame_ready), 0);
        tick(3);
        check("t6_stop_ready_later", 32'(frame_ready), 0);
        check("t6_pending", 32'(exp_q.size()), 0);

        // 6b: reset in the middle of a capture
        for (int k = 0; k <= 52; k++) push(k, 2048 + k);
        pulse_arm();
        tick(2);
        send_ramp(0, 2100);
        tick(1);
        check("t6r_busy_capturing", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check("t6r_busy", 32'(busy), 0);
        check("t6r_wr_en", 32'(wr_en), 0);
        check("t6r_wr_addr", 32'(wr_addr), 0);
        check("t6r_ready", 32'(frame_ready), 0);
        reset = 1'b1;
        tick(3);
        check("t6r_ready_later", 32'(frame_ready), 0);
        check("t6r_idle_later", 32'(busy), 0);
        check("t6r_pending", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
